frame_tx_arbiter: RTL and testbench

Round-robin frame scheduler that shares one byte-level UART transmitter between two requesters. Each granted frame uses the same wire format the RxD receiver decodes: sync bytes 0x55, 0xAA, a length byte L, then L payload bytes. The block sits between the payload sources and the UART TX byte serializer. It owns sequencing, arbitration and inter-frame spacing.

---
 rtl/frame_tx_arbiter.sv | 117 +++++++++++
 tb/tb_frame_tx_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_tx_arbiter.sv
// frame_tx_arbiter: round-robin scheduler framing two payload sources onto one UART TX byte stream.
module frame_tx_arbiter #(
  parameter logic [7:0] SYNC_A = 8'h55,
  parameter logic [7:0] SYNC_B = 8'hAA,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] len0,
  input  logic [7:0] len1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       pop0,
  output logic       pop1,
  output logic       grant0,
  output logic       grant1,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       owner
);
  typedef enum logic [2:0] {IDLE, SYNC1, SYNC2, LEN, DATA, GAP} state_t;
  localparam state_t DONE_ST = (GAP_CYCLES == 0) ? IDLE : GAP;
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);
  state_t state_q, state_d;
  logic [7:0] tx_data_q, tx_data_d, len_q, len_d, cnt_q, cnt_d, gap_q, gap_d, data_sel;
  logic tx_valid_q, tx_valid_d, busy_q, busy_d, owner_q, owner_d, last_q, last_d;
  logic sel, xfer, pop;
  logic [1:0] grant_q, grant_d;
  always_comb begin
    state_d = state_q;
    tx_data_d = tx_data_q;
    tx_valid_d = tx_valid_q;
    grant_d = 2'b00;
    owner_d = owner_q;
    last_d = last_q;
    len_d = len_q;
    cnt_d = cnt_q;
    gap_d = gap_q;
    pop = 1'b0;
    xfer = tx_valid_q & tx_ready;
    sel = (req0 & req1) ? ~last_q : req1;
    data_sel = owner_q ? data1 : data0;
    case (state_q)
      IDLE: if (req0 | req1) begin
        grant_d = sel ? 2'b10 : 2'b01;
        owner_d = sel;
        last_d = sel;
        len_d = sel ? len1 : len0;
        tx_data_d = SYNC_A;
        tx_valid_d = 1'b1;
        state_d = SYNC1;
      end
      SYNC1: if (xfer) begin
        tx_data_d = SYNC_B;
        state_d = SYNC2;
      end
      SYNC2: if (xfer) begin
        tx_data_d = len_q;
        state_d = LEN;
      end
      // LEN and DATA share the "last byte?" decision; cnt loads from len_q so L=255 never wraps
      LEN, DATA: if (xfer) begin
        if ((state_q == LEN) ? (len_q == 8'd0) : (cnt_q == 8'd1)) begin
          tx_valid_d = 1'b0;
          gap_d = GAP_LOAD;
          state_d = DONE_ST;
        end else begin
          tx_data_d = data_sel;
          pop = 1'b1;
          cnt_d = (state_q == LEN) ? len_q : cnt_q - 8'd1;
          state_d = DATA;
        end
      end
      GAP: if (gap_q == 8'd0) state_d = IDLE;
           else gap_d = gap_q - 8'd1;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      tx_data_q <= 8'h00;
      tx_valid_q <= 1'b0;
      grant_q <= 2'b00;
      busy_q <= 1'b0;
      owner_q <= 1'b0;
      last_q <= 1'b1;
      len_q <= 8'h00;
      cnt_q <= 8'h00;
      gap_q <= 8'h00;
    end else begin
      state_q <= state_d;
      tx_data_q <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      grant_q <= grant_d;
      busy_q <= busy_d;
      owner_q <= owner_d;
      last_q <= last_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      gap_q <= gap_d;
    end
  end
  assign pop0 = pop & ~owner_q & ~reset;
  assign pop1 = pop & owner_q & ~reset;
  assign grant0 = grant_q[0];
  assign grant1 = grant_q[1];
  assign tx_data = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy = busy_q;
  assign owner = owner_q;
endmodule

// File: tb/tb_frame_tx_arbiter.sv
// tb_frame_tx_arbiter: directed scoreboard bench for frame_tx_arbiter.
module tb_frame_tx_arbiter;
  localparam logic [7:0] SA = 8'h55;
  localparam logic [7:0] SB = 8'hAA;
  logic clock = 1'b0;
  logic reset, req0, req1, tx_ready, pop0, pop1, grant0, grant1, tx_valid, busy, owner;
  logic [7:0] len0, len1, data0 = 8'h00, data1 = 8'h00, tx_data;
  logic [9:0] sb[$];
  logic [7:0] q0[$], q1[$];
  int n_checks = 0, n_fail = 0, p0 = 0, p1 = 0, g0 = 0, g1 = 0;
  int p0b, p1b, g0b, g1b;
  logic pend0 = 1'b0, pend1 = 1'b0, stall_q = 1'b0;
  logic [7:0] hold_q = 8'h00;

  frame_tx_arbiter dut (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1), .len0(len0), .len1(len1),
    .data0(data0), .data1(data1), .pop0(pop0), .pop1(pop1), .grant0(grant0), .grant1(grant1),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .owner(owner)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard entry: {payload, owner, byte}
  task automatic push_frame(input logic o, input logic [7:0] l, input logic [7:0] base, input logic [7:0] step);
    logic [7:0] b;
    sb.push_back({1'b0, o, SA});
    sb.push_back({1'b0, o, SB});
    sb.push_back({1'b0, o, l});
    for (int i = 0; i < int'(l); i++) begin
      b = base + 8'(i) * step;
      sb.push_back({1'b1, o, b});
      if (o) q1.push_back(b);
      else q0.push_back(b);
    end
  endtask

  task automatic wait_grant(input logic [1:0] exp);
    int k;
    for (k = 0; k < 10; k++) begin
      @(posedge clock); #2;
      if (grant0 | grant1) break;
    end
    chk("grant_latency", 32'(k), 32'd0);
    chk("grant", 32'({grant1, grant0}), 32'(exp));
    chk("first_valid", 32'(tx_valid), 32'd1);
    chk("first_byte", 32'(tx_data), 32'(SA));
    chk("busy_on_grant", 32'(busy), 32'd1);
  endtask

  task automatic wait_drain(input int max, input logic bp, input int left);
    for (int k = 0; k < max; k++) begin
      @(posedge clock); #1;
      if (sb.size() <= left) break;
      tx_ready = bp ? 1'(k % 3 == 0) : 1'b1;
    end
    chk("drain", 32'(sb.size() <= left), 32'd1);
  endtask

  always @(negedge clock) begin
    logic [9:0] e;
    logic [1:0] exp_pop;
    logic xf;
    if (reset) stall_q = 1'b0;
    else begin
      xf = tx_valid && tx_ready;
      exp_pop = (xf && sb.size() > 1 && sb[1][9]) ? (sb[0][8] ? 2'b10 : 2'b01) : 2'b00;
      chk("pop", 32'({pop1, pop0}), 32'(exp_pop));
      if (stall_q && tx_valid) chk("hold", 32'(tx_data), 32'(hold_q));
      stall_q = tx_valid && !tx_ready;
      hold_q = tx_data;
      if (xf) begin
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("tx_data", 32'(tx_data), 32'(e[7:0]));
          chk("owner", 32'(owner), 32'(e[8]));
        end
      end
      pend0 = pop0;
      pend1 = pop1;
      if (pop0) p0++;
      if (pop1) p1++;
      if (grant0) g0++;
      if (grant1) g1++;
    end
  end

  always @(posedge clock) begin
    #1;
    if (pend0 && q0.size() > 0) void'(q0.pop_front());
    if (pend1 && q1.size() > 0) void'(q1.pop_front());
    pend0 = 1'b0;
    pend1 = 1'b0;
    data0 = (q0.size() > 0) ? q0[0] : 8'h00;
    data1 = (q1.size() > 0) ? q1[0] : 8'h00;
  end

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; len0 = 8'h00; len1 = 8'h00; tx_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_grant", 32'({grant1, grant0}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_pop", 32'({pop1, pop0}), 32'd0);
    // single frame
    @(posedge clock); #1;
    push_frame(1'b0, 8'd3, 8'h11, 8'h11);
    len0 = 8'd3; req0 = 1'b1;
    wait_grant(2'b01);
    req0 = 1'b0;
    wait_drain(200, 1'b0, 0);
    @(negedge clock); chk("gap1_busy", 32'(busy), 32'd1);
    @(negedge clock); chk("gap2_busy", 32'(busy), 32'd1);
    chk("gap_valid", 32'(tx_valid), 32'd0);
    @(negedge clock); chk("idle_busy", 32'(busy), 32'd0);
    chk("single_pops", 32'(p0), 32'd3);
    chk("single_grants", 32'(g0), 32'd1);
    // zero length
    @(posedge clock); #1;
    p1b = p1; g1b = g1;
    push_frame(1'b1, 8'd0, 8'h00, 8'h00);
    len1 = 8'd0; req1 = 1'b1;
    wait_grant(2'b10);
    req1 = 1'b0;
    wait_drain(200, 1'b0, 0);
    repeat (5) @(posedge clock);
    #1;
    chk("zero_owner", 32'(owner), 32'd1);
    chk("zero_pops", 32'(p1 - p1b), 32'd0);
    chk("zero_grants", 32'(g1 - g1b), 32'd1);
    // tie and fairness after reset
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    g0b = g0; g1b = g1;
    push_frame(1'b0, 8'd1, 8'hA1, 8'h00);
    push_frame(1'b1, 8'd1, 8'hB1, 8'h00);
    push_frame(1'b0, 8'd1, 8'hA2, 8'h00);
    push_frame(1'b1, 8'd1, 8'hB2, 8'h00);
    q0.delete(); q1.delete();
    q0.push_back(8'hA1); q0.push_back(8'hA2);
    q1.push_back(8'hB1); q1.push_back(8'hB2);
    len0 = 8'd1; len1 = 8'd1; req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(posedge clock); #2;
      if (g0 - g0b >= 2) req0 = 1'b0;
      if (g1 - g1b >= 2) req1 = 1'b0;
      if (sb.size() == 0 && !req0 && !req1) break;
    end
    chk("tie_drain", 32'(sb.size()), 32'd0);
    chk("tie_g0", 32'(g0 - g0b), 32'd2);
    chk("tie_g1", 32'(g1 - g1b), 32'd2);
    repeat (5) @(posedge clock);
    // backpressure
    #1;
    p0b = p0;
    push_frame(1'b0, 8'd4, 8'hD0, 8'h01);
    len0 = 8'd4; req0 = 1'b1;
    wait_grant(2'b01);
    req0 = 1'b0;
    wait_drain(400, 1'b1, 0);
    tx_ready = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    chk("bp_pops", 32'(p0 - p0b), 32'd4);
    // reset mid-payload, after two of five payload bytes
    push_frame(1'b0, 8'd5, 8'h60, 8'h01);
    len0 = 8'd5; req0 = 1'b1;
    wait_grant(2'b01);
    req0 = 1'b0;
    wait_drain(200, 1'b0, 3);
    tx_ready = 1'b0; reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; tx_ready = 1'b1;
    sb.delete(); q0.delete();
    @(negedge clock);
    chk("mid_rst_valid", 32'(tx_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clock); #1;
    push_frame(1'b1, 8'd2, 8'h70, 8'h01);
    len1 = 8'd2; req1 = 1'b1;
    wait_grant(2'b10);
    req1 = 1'b0;
    wait_drain(200, 1'b0, 0);
    repeat (5) @(posedge clock);
    // max length
    #1;
    p0b = p0;
    push_frame(1'b0, 8'd255, 8'h00, 8'h01);
    len0 = 8'd255; req0 = 1'b1;
    wait_grant(2'b01);
    req0 = 1'b0;
    wait_drain(2000, 1'b0, 0);
    repeat (5) @(posedge clock);
    #1;
    chk("max_pops", 32'(p0 - p0b), 32'd255);
    chk("max_valid", 32'(tx_valid), 32'd0);
    chk("max_busy", 32'(busy), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
